// File: rtl/alu_input_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_input_sequencer_if
// Operand bus between the operand-entry sequencer and the downstream ALU.
//   a_o, b_o       : operand registers (N bits)
//   op_o           : 3-bit op code
//   op_sum_o       : sum-mode bit
//   op_subt_o      : subtract-mode bit
//   valid_o        : high while a complete operation is held
//   state_o        : sequencer state, also shown on LEDs
// master : driven by the sequencer
// slave  : read by the ALU / LED logic
// ---------------------------------------------------------------------------
interface alu_input_sequencer_if #(
   parameter int N = 4
);
   logic [N-1:0] a_o;
   logic [N-1:0] b_o;
   logic [2:0]   op_o;
   logic         op_sum_o;
   logic         op_subt_o;
   logic         valid_o;
   logic [1:0]   state_o;

   modport master (
      output a_o, b_o, op_o, op_sum_o, op_subt_o, valid_o, state_o
   );

   modport slave (
      input a_o, b_o, op_o, op_sum_o, op_subt_o, valid_o, state_o
   );
endinterface

// File: rtl/alu_input_sequencer.sv
// ---------------------------------------------------------------------------
// alu_input_sequencer_btn
// Conditions one active-low, bouncing push-button into a single-cycle press
// pulse.
//   clk      : system clock
//   rst_n    : async active-low reset
//   btn_n    : raw button level (low = pressed), asynchronous
//   press_o  : registered one-cycle pulse on a debounced 1->0 transition
//
// The raw level goes through a 2-FF synchronizer. A counter tracks how many
// consecutive synchronized samples have differed from the debounced level;
// any agreeing sample clears it. On the DB_CYCLES-th differing sample the
// debounced level flips and the counter clears, so it never wraps.
// The press pulse is registered off a delayed copy of the debounced level,
// which puts the pulse one cycle after the flip.
// ---------------------------------------------------------------------------
module alu_input_sequencer_btn #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press_o
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          db_q, db_d;
   logic          db_dly_q, db_dly_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = btn_n;
      sync2_d  = sync1_q;
      db_d     = db_q;
      cnt_d    = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      db_dly_d = db_q;
      // Falling debounced edge only; releases produce nothing.
      press_d  = db_dly_q & ~db_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         db_q     <= 1'b1;
         db_dly_q <= 1'b1;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         db_q     <= db_d;
         db_dly_q <= db_dly_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end

   assign press_o = press_q;
endmodule

// ---------------------------------------------------------------------------
// alu_input_sequencer
// Operand-entry front end for the N-bit ALU. One load press advances one
// step: A, then B, then op code + mode bits, then READY; a further load wraps
// back to LOAD_A without disturbing the held operands. A clear press returns
// everything to reset values and wins over a simultaneous load.
//   clk          : system clock, rising edge
//   rst_n        : async active-low reset
//   sw_i         : data switches (N bits), asynchronous
//   op_sw_i      : op-code switches, asynchronous
//   btn_load_n   : load/advance button, active-low, bouncing
//   btn_clear_n  : clear button, active-low, bouncing
//   alu          : operand bus to the ALU (master side)
//
//   state   | meaning
//   --------+-----------------------------------------------
//   LOAD_A  | waiting for load press to capture operand A
//   LOAD_B  | waiting for load press to capture operand B
//   LOAD_OP | waiting for load press to capture op code/mode
//   READY   | operation complete, valid_o high
// ---------------------------------------------------------------------------
module alu_input_sequencer #(
   parameter int N         = 4,
   parameter int DB_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          sw_i,
   input  logic [2:0]            op_sw_i,
   input  logic                  btn_load_n,
   input  logic                  btn_clear_n,
   alu_input_sequencer_if.master alu
);
   typedef enum logic [1:0] {
      LOAD_A  = 2'b00,
      LOAD_B  = 2'b01,
      LOAD_OP = 2'b10,
      READY   = 2'b11
   } state_t;

   localparam logic [2:0] OP_RESET = 3'b111;

   logic load_ev;
   logic clear_ev;

   state_t       state_q, state_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [2:0]   op_q, op_d;
   logic         op_sum_q, op_sum_d;
   logic         op_subt_q, op_subt_d;
   logic         valid_q, valid_d;

   alu_input_sequencer_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_load (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (btn_load_n),
      .press_o (load_ev)
   );

   alu_input_sequencer_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_clear (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (btn_clear_n),
      .press_o (clear_ev)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD_A;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      op_sum_d  = op_sum_q;
      op_subt_d = op_subt_q;

      if (clear_ev) begin
         state_d   = LOAD_A;
         a_d       = '0;
         b_d       = '0;
         op_d      = OP_RESET;
         op_sum_d  = 1'b0;
         op_subt_d = 1'b0;
      end else if (load_ev) begin
         case (state_q)
            LOAD_A: begin
               a_d     = sw_i;
               state_d = LOAD_B;
            end
            LOAD_B: begin
               b_d     = sw_i;
               state_d = LOAD_OP;
            end
            LOAD_OP: begin
               op_d      = op_sw_i;
               op_sum_d  = sw_i[0];
               op_subt_d = sw_i[1];
               state_d   = READY;
            end
            READY: begin
               state_d = LOAD_A;
            end
            default: begin
               state_d = LOAD_A;
            end
         endcase
      end

      // Registered off the next state so valid rises with the op capture.
      valid_d = (state_d == READY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_RESET;
         op_sum_q  <= 1'b0;
         op_subt_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         op_sum_q  <= op_sum_d;
         op_subt_q <= op_subt_d;
         valid_q   <= valid_d;
      end
   end

   assign alu.a_o       = a_q;
   assign alu.b_o       = b_q;
   assign alu.op_o      = op_q;
   assign alu.op_sum_o  = op_sum_q;
   assign alu.op_subt_o = op_subt_q;
   assign alu.valid_o   = valid_q;
   assign alu.state_o   = state_q;
endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Operand-entry front end for the N-bit ALU. Turns active-low push-buttons (low = pressed) and slide switches into registered operand A, operand B, the 3-bit op code and the sum/subtract mode bits, entered one step per press. Holds them stable for the ALU and raises `valid_o` once a complete operation has been entered. Sits directly upstream of the ALU: its outputs drive the ALU's `a`, `b`, `op`, `op_sum` and `op_subt` inputs unchanged.

## Interface
- `N`, 4, operand width; must match the downstream ALU.
- `DB_CYCLES`, 16, consecutive stable samples required to accept a button level change; must be ≥ 2.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw_i`  in  N  data switches, asynchronous to `clk`.
- `op_sw_i`  in  3  op-code switches, asynchronous; passed to the ALU verbatim.
- `btn_load_n`  in  1  load/advance button, active-low, asynchronous, bouncing.
- `btn_clear_n`  in  1  clear button, active-low, asynchronous, bouncing.
- `a_o`  out  N  operand A register.
- `b_o`  out  N  operand B register.
- `op_o`  out  3  op-code register.
- `op_sum_o`  out  1  sum-mode register.
- `op_subt_o`  out  1  subtract-mode register.
- `valid_o`  out  1  high while in READY.
- `state_o`  out  2  current FSM state, for LEDs.

## Operation
- Each button has its own conditioning path:
  - 2-FF synchronizer.
  - Debounce counter comparing the synchronized level to a debounced level (debounced reset value 1, released).
  - Any sample equal to the debounced level resets the counter to 0.
  - After DB_CYCLES consecutive differing samples, the debounced level flips and the counter resets.
- A press event is a registered one-cycle pulse on a debounced 1→0 transition. Releases generate no event.
- Holding a button produces exactly one event.
- FSM states and `state_o` encodings:
  - LOAD_A = 2'b00
  - LOAD_B = 2'b01
  - LOAD_OP = 2'b10
  - READY = 2'b11
- Load event transitions:
  - In LOAD_A: `a_o` ← `sw_i`; go to LOAD_B.
  - In LOAD_B: `b_o` ← `sw_i`; go to LOAD_OP.
  - In LOAD_OP: `op_o` ← `op_sw_i`, `op_sum_o` ← `sw_i[0]`, `op_subt_o` ← `sw_i[1]`; go to READY.
  - In READY: go to LOAD_A. Operand registers keep their values until overwritten.
- Clear event, in any state: go to LOAD_A and return all output registers to their reset values.
- A clear event in the same cycle as a load event takes priority; the load is discarded.
- `valid_o` = (state == READY), registered.
- All data registers change only on events. Between events the outputs are stable regardless of switch activity.

## Timing
- Reset values:
  - `a_o` = 0, `b_o` = 0
  - `op_o` = 3'b111
  - `op_sum_o` = 0, `op_subt_o` = 0
  - `valid_o` = 0
  - `state_o` = 2'b00
  - Both debounced levels = 1; counters and synchronizers cleared to their released state.
- Reset asserted mid-sequence forces the reset values immediately, without waiting for a clock edge.
- After reset deasserts, a button already held low produces one event once it has been debounced.
- Latency: raw button first sampled low at edge k, held low. Debounced level flips at edge k+1+DB_CYCLES, pulse is high in the following cycle, registers and state update at edge k+3+DB_CYCLES.
- `valid_o` rises on the same edge that captures `op_o`. It falls on the edge of the next load or clear update.
- A glitch shorter than DB_CYCLES samples never produces an event, nor does any low run interrupted by a high sample.
- Debounce counter width is $clog2(DB_CYCLES+1). The counter must not wrap; it saturates at reset-to-0 on acceptance.

## Test plan
All scenarios use DB_CYCLES=4.
- Reset: `rst_n` low with buttons released → all outputs at reset values. Assert `rst_n` mid-clock while in LOAD_OP → `state_o`=00 before the next edge.
- Full entry:
  - `sw_i`=4'b1001, press load → `a_o`=1001.
  - `sw_i`=4'b0010, press → `b_o`=0010.
  - `op_sw_i`=3'b101 with `sw_i`=4'b0001, press → `op_o`=101, `op_sum_o`=1, `op_subt_o`=0, `valid_o`=1.
  - Each update lands exactly 7 edges after the first low sample.
- Bounce rejection: load toggles low/high every 2 cycles for 20 cycles, then holds low for 10 cycles → exactly one event; `state_o` advances by one.
- Hold and stability: hold load low for 100 cycles → a single advance. Change `sw_i` while in READY → `a_o` and `b_o` unchanged.
- Clear priority: from LOAD_OP, assert clear and load events in the same cycle → LOAD_A, `a_o`=`b_o`=0, `op_o`=111, `valid_o`=0.
- Wrap: in READY with A=1111, press load → `state_o`=00, `valid_o`=0, `a_o` still 1111 until the next load.
